// File: rtl/timer_bus_arbiter.sv
// rtl/timer_bus_arbiter.sv - round-robin arbiter sharing one timer register slave port among N_REQ masters
module timer_bus_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_address,
    input  logic [N_REQ-1:0]        req_read,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*DATA_W-1:0] req_writedata,
    output logic [N_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]       req_readdata,
    output logic [N_REQ-1:0]        req_readdatavalid,
    output logic                    proto_err,
    output logic [IW-1:0]           grant_idx,
    output logic                    s_address,
    output logic                    s_read,
    output logic                    s_write,
    output logic [DATA_W-1:0]       s_writedata,
    input  logic [DATA_W-1:0]       s_readdata
);

    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     winner;
    logic [N_REQ-1:0]  pend;
    logic [N_REQ-1:0]  win_oh;
    logic              found;
    logic              gnt;
    logic              rd_win;
    logic              wr_win;
    logic              adr_win;
    logic [DATA_W-1:0] wd_win;

    // Scan rr_ptr, rr_ptr+1, ... with an explicit modulo so non-power-of-two N_REQ wraps correctly.
    always_comb begin
        pend   = req_read | req_write;
        win_oh = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && pend[j] && (j == (int'(rr_ptr) + k) % N_REQ)) begin
                    found     = 1'b1;
                    win_oh[j] = 1'b1;
                    winner    = IW'(j);
                end
            end
        end

        wd_win = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (win_oh[j]) begin
                wd_win = req_writedata[j*DATA_W +: DATA_W];
            end
        end
        rd_win  = |(req_read & win_oh);
        wr_win  = |(req_write & win_oh);
        adr_win = |(req_address & win_oh);

        // Nothing reaches the timer while reset is asserted; masters keep holding their commands.
        gnt             = found & reset;
        s_write         = gnt & wr_win;
        s_read          = gnt & rd_win & ~wr_win;
        s_address       = gnt & adr_win;
        s_writedata     = gnt ? wd_win : '0;
        req_waitrequest = gnt ? (pend & ~win_oh) : pend;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr            <= '0;
            grant_idx         <= '0;
            req_readdata      <= '0;
            req_readdatavalid <= '0;
            proto_err         <= 1'b0;
        end else begin
            req_readdatavalid <= '0;
            if (found) begin
                rr_ptr    <= (int'(winner) == N_REQ - 1) ? '0 : winner + IW'(1);
                grant_idx <= winner;
                if (rd_win && !wr_win) begin
                    req_readdata      <= s_readdata;
                    req_readdatavalid <= win_oh;
                end
                if (rd_win && wr_win) begin
                    proto_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// tb/tb_timer_bus_arbiter.sv - directed self-checking bench for timer_bus_arbiter
module tb_timer_bus_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_address = '0;
    logic [N-1:0]   req_read = '0;
    logic [N-1:0]   req_write = '0;
    logic [N*W-1:0] req_writedata = '0;
    logic [N-1:0]   req_waitrequest;
    logic [W-1:0]   req_readdata;
    logic [N-1:0]   req_readdatavalid;
    logic           proto_err;
    logic [1:0]     grant_idx;
    logic           s_address;
    logic           s_read;
    logic           s_write;
    logic [W-1:0]   s_writedata;
    logic [W-1:0]   s_readdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
    } sb_t;
    sb_t         sb[$];
    sb_t         sb_e;
    logic [31:0] wdata[N];
    logic [1:0]  exp_gidx;
    logic        exp_perr;

    timer_bus_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .req_address(req_address),
        .req_read(req_read),
        .req_write(req_write),
        .req_writedata(req_writedata),
        .req_waitrequest(req_waitrequest),
        .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .proto_err(proto_err),
        .grant_idx(grant_idx),
        .s_address(s_address),
        .s_read(s_read),
        .s_write(s_write),
        .s_writedata(s_writedata),
        .s_readdata(s_readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (req_readdatavalid !== '0) begin
            if (sb.size() == 0) begin
                chk("rdv_unexpected", 64'(req_readdatavalid), 64'd0);
            end else begin
                sb_e = sb.pop_front();
                chk("rdv_onehot", 64'(req_readdatavalid), 64'(4'b0001 << sb_e.idx));
                chk("rdata", 64'(req_readdata), 64'(sb_e.data));
            end
        end
    end

    task automatic step(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] adr,
                        input logic g, input logic [1:0] win, input logic [31:0] tval);
        logic [3:0] pend;
        req_read    = rd;
        req_write   = wr;
        req_address = adr;
        s_readdata  = tval;
        pend        = rd | wr;
        @(negedge clk);
        if (!g) begin
            chk("idle_s_read", 64'(s_read), 64'd0);
            chk("idle_s_write", 64'(s_write), 64'd0);
            chk("idle_s_address", 64'(s_address), 64'd0);
            chk("idle_s_writedata", 64'(s_writedata), 64'd0);
            chk("idle_waitrequest", 64'(req_waitrequest), 64'd0);
        end else begin
            chk("s_write", 64'(s_write), 64'(wr[win]));
            chk("s_read", 64'(s_read), 64'(rd[win] & ~wr[win]));
            chk("s_address", 64'(s_address), 64'(adr[win]));
            chk("s_writedata", 64'(s_writedata), 64'(wdata[win]));
            chk("waitrequest", 64'(req_waitrequest), 64'(pend & ~(4'b0001 << win)));
            if (rd[win] && !wr[win]) sb.push_back('{win, tval});
            if (rd[win] && wr[win]) exp_perr = 1'b1;
            exp_gidx = win;
        end
        @(posedge clk);
        #1;
        chk("grant_idx", 64'(grant_idx), 64'(exp_gidx));
        chk("proto_err", 64'(proto_err), 64'(exp_perr));
    endtask

    initial begin
        wdata[0] = 32'hA5A5_0000;
        wdata[1] = 32'h0000_0001;
        wdata[2] = 32'h5A5A_0002;
        wdata[3] = 32'h0000_0000;
        for (int i = 0; i < N; i++) req_writedata[i*W +: W] = wdata[i];
        exp_gidx = 2'd0;
        exp_perr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        chk("rst_readdata", 64'(req_readdata), 64'd0);
        chk("rst_rdv", 64'(req_readdatavalid), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("rst_s_read", 64'(s_read), 64'd0);
        chk("rst_s_write", 64'(s_write), 64'd0);
        reset = 1'b1;

        // requester 1 writes CTRL=1, leaving rr_ptr at 2
        step(4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 32'h0000_0011);
        // 0 and 3 both pending: rr_ptr=2 must pick 3, then rr_ptr wraps to 0
        step(4'b1001, 4'b0000, 4'b1001, 1'b1, 2'd3, 32'h0000_0020);
        // all four read COUNTER continuously from rr_ptr=0
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'b0000, 4'b1111, 1'b1, 2'(i % 4), 32'h0000_0100 + 32'(i));
        end
        // rr_ptr=0 -> requester 0 alone moves it to 1
        step(4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 32'h0000_0004);
        // 0 and 2 with rr_ptr=1: 2 first, then 0
        step(4'b0101, 4'b0000, 4'b0101, 1'b1, 2'd2, 32'h0000_0005);
        step(4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 32'h0000_0006);
        // read and write together on requester 3
        step(4'b1000, 4'b1000, 4'b0000, 1'b1, 2'd3, 32'h0000_0007);
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'hDEAD_0000 + 32'(i));
            chk("rdata_hold", 64'(req_readdata), 64'h6);
        end
        // idle after grant_idx=2
        step(4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 32'h0000_0008);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'hBEEF_0000 + 32'(i));
        end

        // read presented in the cycle reset is sampled low
        req_read    = 4'b0010;
        req_address = 4'b0010;
        s_readdata  = 32'h0000_0099;
        reset       = 1'b0;
        @(negedge clk);
        chk("rstmid_s_read", 64'(s_read), 64'd0);
        chk("rstmid_s_address", 64'(s_address), 64'd0);
        chk("rstmid_s_writedata", 64'(s_writedata), 64'd0);
        @(posedge clk);
        #1;
        exp_gidx = 2'd0;
        exp_perr = 1'b0;
        chk("rstmid_rdv", 64'(req_readdatavalid), 64'd0);
        chk("rstmid_readdata", 64'(req_readdata), 64'd0);
        chk("rstmid_grant_idx", 64'(grant_idx), 64'd0);
        chk("rstmid_proto_err", 64'(proto_err), 64'd0);
        reset = 1'b1;
        // rr_ptr back at 0: with all pending, 0 wins
        step(4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0, 32'h0000_0009);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0000_0000);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0000_0000);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_bus_arbiter.md
Name: timer_bus_arbiter

Overview:
- Round-robin arbiter that shares one timer register slave port (1-bit address, read, write, 32-bit writedata, combinational readdata) among N_REQ masters (e.g. CPU, DMA, debug).
- Sits between requesters and the timer peripheral.
- Serialises single-cycle register transactions and returns registered read data with a per-requester valid pulse.
- Flags protocol violations.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, data width of the timer slave port.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- req_address  input  N_REQ  per-requester register select (bit i = requester i); 0 selects CTRL, 1 selects COUNTER.
- req_read  input  N_REQ  per-requester read strobe.
- req_write  input  N_REQ  per-requester write strobe.
- req_writedata  input  N_REQ*DATA_W  per-requester write data; requester i uses bits [i*DATA_W +: DATA_W].
- req_waitrequest  output  N_REQ  high = requester must hold its command.
- req_readdata  output  DATA_W  shared registered read data.
- req_readdatavalid  output  N_REQ  one-hot read-return pulse.
- proto_err  output  1  sticky: requester asserted read and write in the same cycle.
- grant_idx  output  $clog2(N_REQ)  index of the current/last granted requester (debug).
- s_address  output  1  to timer address.
- s_read  output  1  to timer read.
- s_write  output  1  to timer write.
- s_writedata  output  DATA_W  to timer writedata.
- s_readdata  input  DATA_W  from timer readdata (combinational, valid the same cycle as s_read).

Behaviour:
- Reset (reset==0 at a clk edge):
  - rr_ptr=0, grant_idx=0, req_readdata=0, req_readdatavalid=0, proto_err=0.
  - s_read, s_write, s_address and s_writedata are driven 0 while reset is low.
- Pending request: pend[i] = req_read[i] | req_write[i].
- Arbitration (combinational, every cycle):
  - Winner is the first i with pend[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - At most one grant per cycle.
- Granted cycle: winner's address, read, write and writedata drive s_* in the same cycle.
  - req_waitrequest[winner]=0.
  - req_waitrequest[j]=1 for every other pending j.
  - req_waitrequest[j]=0 for non-pending j.
- No pending request: s_read=s_write=0, s_address=0, s_writedata=0, all waitrequest=0.
- Pointer update at the clk edge after a grant: rr_ptr <= (winner+1) mod N_REQ and grant_idx <= winner.
  - With no grant, rr_ptr and grant_idx hold.
- Read latency is 1 cycle:
  - On a granted read, s_readdata is captured into req_readdata.
  - req_readdatavalid[winner] pulses high for exactly the following cycle.
  - Otherwise req_readdatavalid=0 and req_readdata holds its last value.
- Writes: forwarded in the granted cycle; no response pulse.
- Read and write both high on the winner:
  - write wins; s_read=0 and no readdatavalid is issued.
  - proto_err <= 1, which stays set until reset.
- Back-to-back: a requester holding pend continuously while others are also pending is granted once every N_REQ cycles at most (fairness). A requester alone is granted every cycle.
- A requester that drops its command while waited is simply not considered; no state is kept per requester.
- Reset mid-transaction:
  - A read granted in the cycle reset is sampled low produces no readdatavalid.
  - A pending write in that cycle is not forwarded.
- N_REQ not a power of two: modulo wrap of rr_ptr is explicit (N_REQ-1 -> 0).

Test Plan:
- Reset, then requester 1 writes CTRL=0x1 -> s_write=1, s_address=0, s_writedata=0x1 in the same cycle; waitrequest[1]=0; grant_idx=1 next cycle; rr_ptr=2.
- All 4 requesters read COUNTER continuously from rr_ptr=0 -> grant order 0,1,2,3,0,...; each sees readdatavalid one cycle after its grant; each waitrequest is low 1 cycle in 4.
- Requesters 0 and 2 both read with rr_ptr=1 -> 2 granted first, then 0; req_readdata matches s_readdata sampled on each grant cycle (e.g. 0x0000_0005, 0x0000_0006).
- Requester 3 asserts read and write together with writedata=0x0 -> s_write=1, s_read=0, no readdatavalid, proto_err=1 held through 10 idle cycles.
- Read granted in the same cycle reset goes low -> no readdatavalid; after reset all outputs are 0, proto_err=0, rr_ptr=0.
- Idle (no requests) for 5 cycles after grant_idx=2 -> s_read=s_write=0, all waitrequest=0, grant_idx stays 2.
